// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the write-back stage.
package wb_stage_pkg;

    localparam int GPR_NUM     = 32;
    localparam int GPR_AW      = $clog2(GPR_NUM);
    localparam int SINGLE_WORD = 32;
    localparam int LOAD_SEL_W  = 7;

    // Bit positions inside the one-hot load select vector
    localparam int LS_LB  = 0;
    localparam int LS_LBU = 1;
    localparam int LS_LH  = 2;
    localparam int LS_LHU = 3;
    localparam int LS_LW  = 4;
    localparam int LS_LWL = 5;
    localparam int LS_LWR = 6;

    // Everything WB keeps from the MEM stage for one instruction
    typedef struct packed {
        logic [GPR_AW-1:0]      write_num;
        logic [SINGLE_WORD-1:0] vaddr;
        logic [SINGLE_WORD-1:0] final_res;
        logic [SINGLE_WORD-1:0] rt_data;
        logic                   mem_req;
        logic [LOAD_SEL_W-1:0]  load_sel;
        logic [1:0]             align;
    } wb_payload_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment, extension and LWL/LWR merge with per-byte enables.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [LOAD_SEL_W-1:0]  i_load_sel,
    input  logic [1:0]             i_off,
    input  logic [SINGLE_WORD-1:0] i_rdata,
    input  logic [SINGLE_WORD-1:0] i_rt,
    output logic [SINGLE_WORD-1:0] o_wdata,
    output logic [3:0]             o_byte_wen
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte/halfword, then extend or merge by load type
    always_comb begin
        w_byte     = 8'h00;
        w_half     = 16'h0000;
        o_wdata    = i_rdata;
        o_byte_wen = 4'hF;

        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // off[0] is not looked at: misaligned halfwords never get this far
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        if (i_load_sel[LS_LB]) begin
            o_wdata = {{24{w_byte[7]}}, w_byte};
        end else if (i_load_sel[LS_LBU]) begin
            o_wdata = {24'h000000, w_byte};
        end else if (i_load_sel[LS_LH]) begin
            o_wdata = {{16{w_half[15]}}, w_half};
        end else if (i_load_sel[LS_LHU]) begin
            o_wdata = {16'h0000, w_half};
        end else if (i_load_sel[LS_LWL]) begin
            case (i_off)
                2'd0: begin o_wdata = {i_rdata[7:0],  i_rt[23:0]}; o_byte_wen = 4'b1000; end
                2'd1: begin o_wdata = {i_rdata[15:0], i_rt[15:0]}; o_byte_wen = 4'b1100; end
                2'd2: begin o_wdata = {i_rdata[23:0], i_rt[7:0]};  o_byte_wen = 4'b1110; end
                default: begin o_wdata = i_rdata;                  o_byte_wen = 4'b1111; end
            endcase
        end else if (i_load_sel[LS_LWR]) begin
            case (i_off)
                2'd0: begin o_wdata = i_rdata;                       o_byte_wen = 4'b1111; end
                2'd1: begin o_wdata = {i_rt[31:24], i_rdata[31:8]};  o_byte_wen = 4'b0111; end
                2'd2: begin o_wdata = {i_rt[31:16], i_rdata[31:16]}; o_byte_wen = 4'b0011; end
                default: begin o_wdata = {i_rt[31:8], i_rdata[31:24]}; o_byte_wen = 4'b0001; end
            endcase
        end else begin
            o_wdata = i_rdata;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: last pipeline stage. Registers the MEM payload, captures
// the data-bus read word, aligns load data and drives the GPR write port,
// forwarding and trace outputs.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter bit          TRACE_EN = 1'b1,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_valid_w_i,
    input  logic [GPR_AW-1:0]      MEM_writeNum_i,
    input  logic [SINGLE_WORD-1:0] MEM_VAddr_i,
    input  logic [SINGLE_WORD-1:0] MEM_finalRes_i,
    input  logic [SINGLE_WORD-1:0] MEM_rtData_i,
    input  logic                   MEM_memReq_i,
    input  logic [LOAD_SEL_W-1:0]  MEM_loadSel_i,
    input  logic [1:0]             MEM_alignCheck_i,
    input  logic [SINGLE_WORD-1:0] data_rdata,
    input  logic                   data_data_ok,
    output logic                   WB_allowin_w_o,
    output logic                   WB_hasRisk_w_o,
    output logic                   WB_forwardMode_w_o,
    output logic [GPR_AW-1:0]      WB_writeNum_w_o,
    output logic                   WB_rfWen_o,
    output logic [GPR_AW-1:0]      WB_rfWaddr_o,
    output logic [SINGLE_WORD-1:0] WB_rfWdata_o,
    output logic [SINGLE_WORD-1:0] debug_wb_pc,
    output logic [3:0]             debug_wb_rf_wen,
    output logic [GPR_AW-1:0]      debug_wb_rf_wnum,
    output logic [SINGLE_WORD-1:0] debug_wb_rf_wdata
);

    logic                   r_has_data;
    wb_payload_t            r_pl;
    logic [SINGLE_WORD-1:0] r_rdata;

    wb_payload_t            w_pl_in;
    logic                   w_is_load;
    logic [SINGLE_WORD-1:0] w_align_data;
    logic [3:0]             w_align_wen;
    logic [SINGLE_WORD-1:0] w_wdata;
    logic [3:0]             w_byte_wen;
    logic                   w_rf_wen;

    assign w_pl_in = '{
        write_num: MEM_writeNum_i,
        vaddr:     MEM_VAddr_i,
        final_res: MEM_finalRes_i,
        rt_data:   MEM_rtData_i,
        mem_req:   MEM_memReq_i,
        load_sel:  MEM_loadSel_i,
        align:     MEM_alignCheck_i
    };

    // Pipeline register; a bubble clears the payload so it can never write
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_has_data <= 1'b0;
            r_pl       <= '0;
        end else begin
            r_has_data <= MEM_valid_w_i;
            r_pl       <= MEM_valid_w_i ? w_pl_in : '0;
        end
    end

    // Read word is sampled only when a valid load completes on the bus
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (MEM_valid_w_i && MEM_memReq_i && data_data_ok) begin
            r_rdata <= data_rdata;
        end
    end

    load_align u_load_align (
        .i_load_sel (r_pl.load_sel),
        .i_off      (r_pl.align),
        .i_rdata    (r_rdata),
        .i_rt       (r_pl.rt_data),
        .o_wdata    (w_align_data),
        .o_byte_wen (w_align_wen)
    );

    // Stores carry a zero load select and fall through to the ALU result
    assign w_is_load  = r_pl.mem_req && (|r_pl.load_sel);
    assign w_wdata    = w_is_load ? w_align_data : r_pl.final_res;
    assign w_byte_wen = w_is_load ? w_align_wen  : 4'hF;
    assign w_rf_wen   = r_has_data && (r_pl.write_num != '0);

    assign WB_allowin_w_o     = 1'b1;
    assign WB_hasRisk_w_o     = 1'b0;
    assign WB_forwardMode_w_o = r_has_data;
    assign WB_writeNum_w_o    = r_pl.write_num;
    assign WB_rfWen_o         = w_rf_wen;
    assign WB_rfWaddr_o       = r_pl.write_num;
    assign WB_rfWdata_o       = w_wdata;

    generate
        if (TRACE_EN) begin : g_trace
            assign debug_wb_pc       = r_has_data ? r_pl.vaddr : RESET_PC;
            assign debug_wb_rf_wen   = w_rf_wen ? w_byte_wen : 4'h0;
            assign debug_wb_rf_wnum  = r_pl.write_num;
            assign debug_wb_rf_wdata = w_wdata;
        end else begin : g_no_trace
            assign debug_wb_pc       = '0;
            assign debug_wb_rf_wen   = '0;
            assign debug_wb_rf_wnum  = '0;
            assign debug_wb_rf_wdata = '0;
        end
    endgenerate

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

    localparam logic [31:0] RPC = 32'hBFC0_0000;
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_LB   = 7'b0000001;
    localparam logic [6:0] S_LBU  = 7'b0000010;
    localparam logic [6:0] S_LH   = 7'b0000100;
    localparam logic [6:0] S_LHU  = 7'b0001000;
    localparam logic [6:0] S_LW   = 7'b0010000;
    localparam logic [6:0] S_LWL  = 7'b0100000;
    localparam logic [6:0] S_LWR  = 7'b1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_valid_w_i;
    logic [4:0]  MEM_writeNum_i;
    logic [31:0] MEM_VAddr_i;
    logic [31:0] MEM_finalRes_i;
    logic [31:0] MEM_rtData_i;
    logic        MEM_memReq_i;
    logic [6:0]  MEM_loadSel_i;
    logic [1:0]  MEM_alignCheck_i;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        WB_allowin_w_o;
    logic        WB_hasRisk_w_o;
    logic        WB_forwardMode_w_o;
    logic [4:0]  WB_writeNum_w_o;
    logic        WB_rfWen_o;
    logic [4:0]  WB_rfWaddr_o;
    logic [31:0] WB_rfWdata_o;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks = 0;
    int failures = 0;

    wb_stage dut (
        .clk                (clk),
        .rst                (rst),
        .MEM_valid_w_i      (MEM_valid_w_i),
        .MEM_writeNum_i     (MEM_writeNum_i),
        .MEM_VAddr_i        (MEM_VAddr_i),
        .MEM_finalRes_i     (MEM_finalRes_i),
        .MEM_rtData_i       (MEM_rtData_i),
        .MEM_memReq_i       (MEM_memReq_i),
        .MEM_loadSel_i      (MEM_loadSel_i),
        .MEM_alignCheck_i   (MEM_alignCheck_i),
        .data_rdata         (data_rdata),
        .data_data_ok       (data_data_ok),
        .WB_allowin_w_o     (WB_allowin_w_o),
        .WB_hasRisk_w_o     (WB_hasRisk_w_o),
        .WB_forwardMode_w_o (WB_forwardMode_w_o),
        .WB_writeNum_w_o    (WB_writeNum_w_o),
        .WB_rfWen_o         (WB_rfWen_o),
        .WB_rfWaddr_o       (WB_rfWaddr_o),
        .WB_rfWdata_o       (WB_rfWdata_o),
        .debug_wb_pc        (debug_wb_pc),
        .debug_wb_rf_wen    (debug_wb_rf_wen),
        .debug_wb_rf_wnum   (debug_wb_rf_wnum),
        .debug_wb_rf_wdata  (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  wn;
        logic [31:0] pc;
        logic [31:0] fres;
        logic [31:0] rt;
        logic        mreq;
        logic [6:0]  sel;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic        dok;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [3:0]  e_twen;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] wn, input logic [31:0] pc,
                         input logic [31:0] fres, input logic [31:0] rt, input logic mreq,
                         input logic [6:0] sel, input logic [1:0] off,
                         input logic [31:0] rdata, input logic dok);
        MEM_valid_w_i    = v;
        MEM_writeNum_i   = wn;
        MEM_VAddr_i      = pc;
        MEM_finalRes_i   = fres;
        MEM_rtData_i     = rt;
        MEM_memReq_i     = mreq;
        MEM_loadSel_i    = sel;
        MEM_alignCheck_i = off;
        data_rdata       = rdata;
        data_data_ok     = dok;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string nm, input logic e_wen, input logic [4:0] e_waddr,
                             input logic [31:0] e_wdata, input logic [3:0] e_twen,
                             input logic [31:0] e_pc, input logic e_fwd);
        chk({nm, ".rfWen"},    {31'b0, WB_rfWen_o},         {31'b0, e_wen});
        chk({nm, ".waddr"},    {27'b0, WB_rfWaddr_o},       {27'b0, e_waddr});
        chk({nm, ".wdata"},    WB_rfWdata_o,                e_wdata);
        chk({nm, ".fwdMode"},  {31'b0, WB_forwardMode_w_o}, {31'b0, e_fwd});
        chk({nm, ".fwdNum"},   {27'b0, WB_writeNum_w_o},    {27'b0, e_waddr});
        chk({nm, ".tr_wen"},   {28'b0, debug_wb_rf_wen},    {28'b0, e_twen});
        chk({nm, ".tr_pc"},    debug_wb_pc,                 e_pc);
        chk({nm, ".tr_wnum"},  {27'b0, debug_wb_rf_wnum},   {27'b0, e_waddr});
        chk({nm, ".tr_wdata"}, debug_wb_rf_wdata,           e_wdata);
    endtask

    initial begin
        //          name        v  wn    pc             fres           rt             mreq sel     off rdata          dok  wen waddr wdata          twen   pc
        vecs[0]  = '{"alu",      1, 5'd8, 32'hBFC0_0100, 32'h1234_5678, 32'h0,         0, S_NONE, 0, 32'h0,          0,  1, 5'd8, 32'h1234_5678, 4'hF, 32'hBFC0_0100};
        vecs[1]  = '{"lb_off3",  1, 5'd9, 32'hBFC0_0104, 32'h0,         32'h0,         1, S_LB,   3, 32'h80AB_CDEF,  1,  1, 5'd9, 32'hFFFF_FF80, 4'hF, 32'hBFC0_0104};
        vecs[2]  = '{"lbu_off3", 1, 5'd9, 32'hBFC0_0108, 32'h0,         32'h0,         1, S_LBU,  3, 32'h80AB_CDEF,  1,  1, 5'd9, 32'h0000_0080, 4'hF, 32'hBFC0_0108};
        vecs[3]  = '{"lb_off1",  1, 5'd2, 32'hBFC0_010C, 32'h0,         32'h0,         1, S_LB,   1, 32'h80AB_CDEF,  1,  1, 5'd2, 32'hFFFF_FFCD, 4'hF, 32'hBFC0_010C};
        vecs[4]  = '{"lh_off2",  1, 5'd3, 32'hBFC0_0110, 32'h0,         32'h0,         1, S_LH,   2, 32'h80AB_CDEF,  1,  1, 5'd3, 32'hFFFF_80AB, 4'hF, 32'hBFC0_0110};
        vecs[5]  = '{"lhu_off0", 1, 5'd3, 32'hBFC0_0114, 32'h0,         32'h0,         1, S_LHU,  0, 32'h80AB_CDEF,  1,  1, 5'd3, 32'h0000_CDEF, 4'hF, 32'hBFC0_0114};
        vecs[6]  = '{"lh_off1",  1, 5'd4, 32'hBFC0_0118, 32'h0,         32'h0,         1, S_LH,   1, 32'h80AB_CDEF,  1,  1, 5'd4, 32'hFFFF_CDEF, 4'hF, 32'hBFC0_0118};
        vecs[7]  = '{"lw",       1, 5'd31,32'hBFC0_011C, 32'h0,         32'h0,         1, S_LW,   0, 32'hDEAD_BEEF,  1,  1, 5'd31,32'hDEAD_BEEF, 4'hF, 32'hBFC0_011C};
        vecs[8]  = '{"lwl_off1", 1, 5'd7, 32'hBFC0_0120, 32'h0,         32'h1122_3344, 1, S_LWL,  1, 32'hAABB_CCDD,  1,  1, 5'd7, 32'hCCDD_3344, 4'hC, 32'hBFC0_0120};
        vecs[9]  = '{"lwl_off0", 1, 5'd7, 32'hBFC0_0124, 32'h0,         32'h1122_3344, 1, S_LWL,  0, 32'hAABB_CCDD,  1,  1, 5'd7, 32'hDD22_3344, 4'h8, 32'hBFC0_0124};
        vecs[10] = '{"lwl_off3", 1, 5'd7, 32'hBFC0_0128, 32'h0,         32'h1122_3344, 1, S_LWL,  3, 32'hAABB_CCDD,  1,  1, 5'd7, 32'hAABB_CCDD, 4'hF, 32'hBFC0_0128};
        vecs[11] = '{"lwr_off2", 1, 5'd6, 32'hBFC0_012C, 32'h0,         32'h1122_3344, 1, S_LWR,  2, 32'hAABB_CCDD,  1,  1, 5'd6, 32'h1122_AABB, 4'h3, 32'hBFC0_012C};
        vecs[12] = '{"lwr_off3", 1, 5'd6, 32'hBFC0_0130, 32'h0,         32'h1122_3344, 1, S_LWR,  3, 32'hAABB_CCDD,  1,  1, 5'd6, 32'h1122_33AA, 4'h1, 32'hBFC0_0130};
        vecs[13] = '{"lwr_off1", 1, 5'd6, 32'hBFC0_0134, 32'h0,         32'h1122_3344, 1, S_LWR,  1, 32'hAABB_CCDD,  1,  1, 5'd6, 32'h11AA_BBCC, 4'h7, 32'hBFC0_0134};
        vecs[14] = '{"wn_zero",  1, 5'd0, 32'hBFC0_0138, 32'h0000_0055, 32'h0,         0, S_NONE, 0, 32'h0,          0,  0, 5'd0, 32'h0000_0055, 4'h0, 32'hBFC0_0138};
        vecs[15] = '{"store",    1, 5'd0, 32'hBFC0_013C, 32'h0000_0077, 32'h0,         1, S_NONE, 0, 32'h9999_9999,  1,  0, 5'd0, 32'h0000_0077, 4'h0, 32'hBFC0_013C};
        vecs[16] = '{"bubble",   0, 5'd12,32'hBFC0_0140, 32'hABCD_0000, 32'h0,         1, S_LW,   0, 32'h5555_5555,  1,  0, 5'd0, 32'h0000_0000, 4'h0, RPC};

        // Reset held with a valid instruction presented
        rst = 1'b0;
        drive(1, 5'd5, 32'hBFC0_0F00, 32'hFFFF_0000, 32'h0, 0, S_NONE, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("reset", 0, 5'd0, 32'h0, 4'h0, RPC, 0);
        end
        chk("allowin", {31'b0, WB_allowin_w_o}, 32'd1);
        chk("hasRisk", {31'b0, WB_hasRisk_w_o}, 32'd0);

        // First instruction after release
        rst = 1'b1;
        drive(1, 5'd8, 32'hBFC0_0004, 32'h1234_5678, 32'h0, 0, S_NONE, 0, 32'h0, 0);
        step();
        check_all("release", 1, 5'd8, 32'h1234_5678, 4'hF, 32'hBFC0_0004, 1);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].valid, vecs[i].wn, vecs[i].pc, vecs[i].fres, vecs[i].rt,
                  vecs[i].mreq, vecs[i].sel, vecs[i].off, vecs[i].rdata, vecs[i].dok);
            step();
            check_all(vecs[i].name, vecs[i].e_wen, vecs[i].e_waddr, vecs[i].e_wdata,
                      vecs[i].e_twen, vecs[i].e_pc, vecs[i].valid);
        end

        // data_ok without valid must not overwrite the captured read word
        drive(1, 5'd3, 32'hBFC0_0200, 32'h0, 32'h0, 1, S_LW, 0, 32'h1234_5678, 1);
        step();
        check_all("hold_ld", 1, 5'd3, 32'h1234_5678, 4'hF, 32'hBFC0_0200, 1);
        drive(0, 5'd0, 32'h0, 32'h0, 32'h0, 1, S_LW, 0, 32'hFFFF_FFFF, 1);
        step();
        check_all("hold_bub", 0, 5'd0, 32'h0, 4'h0, RPC, 0);
        drive(1, 5'd3, 32'hBFC0_0204, 32'h0, 32'h0, 1, S_LW, 0, 32'h0, 0);
        step();
        check_all("hold_chk", 1, 5'd3, 32'h1234_5678, 4'hF, 32'hBFC0_0204, 1);

        // Back-to-back loads each see their own read word
        drive(1, 5'd10, 32'hBFC0_0300, 32'h0, 32'h0, 1, S_LW, 0, 32'h1111_1111, 1);
        step();
        check_all("b2b_0", 1, 5'd10, 32'h1111_1111, 4'hF, 32'hBFC0_0300, 1);
        drive(1, 5'd11, 32'hBFC0_0304, 32'h0, 32'h0, 1, S_LW, 0, 32'h2222_2222, 1);
        step();
        check_all("b2b_1", 1, 5'd11, 32'h2222_2222, 4'hF, 32'hBFC0_0304, 1);

        // Reset coinciding with a load discards it and clears the read word
        rst = 1'b0;
        drive(1, 5'd4, 32'hBFC0_0400, 32'h0, 32'h0, 1, S_LW, 0, 32'hCAFE_F00D, 1);
        step();
        check_all("rst_ld", 0, 5'd0, 32'h0, 4'h0, RPC, 0);
        rst = 1'b1;
        drive(1, 5'd4, 32'hBFC0_0404, 32'h0, 32'h0, 1, S_LW, 0, 32'h0, 0);
        step();
        check_all("rst_after", 1, 5'd4, 32'h0, 4'hF, 32'hBFC0_0404, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
